fifo_umbral: RTL and testbench
==============================

# fifo_umbral

Threshold-aware synchronous FIFO that buffers data words and reports occupancy status to the control state machine. It sits directly upstream of the control FSM. It drives that FSM's `FIFO_empty` and `FIFO_error` inputs, and it consumes the per-FIFO threshold fields the FSM publishes while in INIT/IDLE/ACTIVE. One instance exists per buffered stream (main, virtual-channel and destination FIFOs). Each instance is sized by parameter.

## Interface

**Parameters**

- `DATA_W`, default 6: width of a data word.
- `ADDR_W`, default 4: address width. Depth is 2^ADDR_W, which is 16 entries at the default.

**Ports**

- `clk` input, 1: single clock. All state updates on the rising edge.
- `reset` input, 1: reset is asynchronous and active-low. `reset`=0 clears all state immediately.
- `push` input, 1: write request. `data_in` is written on the edge where `push`=1 and the write is accepted.
- `data_in` input, DATA_W: write data.
- `pop` input, 1: read request.
- `umbral_we` input, 1: load strobe for the threshold registers.
- `umbral_alto` input, ADDR_W: almost-full threshold.
- `umbral_bajo` input, ADDR_W: almost-empty threshold.
- `data_out` output, DATA_W: registered read data.
- `valid_out` output, 1: one-cycle pulse, high when `data_out` holds a newly read word.
- `fifo_empty` output, 1: high when occupancy is 0.
- `fifo_full` output, 1: high when occupancy is 2^ADDR_W.
- `almost_empty` output, 1: high when occupancy ≤ `umbral_bajo` (registered threshold).
- `almost_full` output, 1: high when occupancy ≥ `umbral_alto` (registered threshold).
- `fifo_error` output, 1: overflow/underflow indication. Its persistence is set under Configuration.

## Operation

**State**
- Write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_W bits. Both wrap modulo 2^ADDR_W with natural binary rollover.
- Occupancy counter `count`, ADDR_W+1 bits, range 0..2^ADDR_W.
- Threshold registers `th_alto` and `th_bajo`.
- `data_out`, `valid_out` and `fifo_error` registers.

**Reset values**
- Pointers = 0 and `count` = 0.
- `th_alto` = 2^ADDR_W−1 and `th_bajo` = 0.
- `data_out` = 0, `valid_out` = 0 and `fifo_error` = 0.
- Resulting flags: `fifo_empty`=1, `almost_empty`=1, `fifo_full`=0, `almost_full`=0.

**Thresholds**
- On an edge with `umbral_we`=1, load `th_alto`←`umbral_alto` and `th_bajo`←`umbral_bajo`. Otherwise hold.
- The integrator drives `umbral_we` from the FSM's `idle_out`. Zeroed threshold fields from FSM states RESET and ERROR are therefore never captured.

**Per-edge decisions** (all evaluated against the pre-edge `count`)
- **Pop accepted** when `pop`=1 and `count`>0. On acceptance:
  - `data_out`←mem[`rd_ptr`]
  - `valid_out`←1
  - `rd_ptr` increments.
- **Pop rejected** when `pop`=1 and `count`=0. Underflow: nothing is read, `valid_out`←0, error event raised.
- **Push accepted** when `push`=1 and either `count`<2^ADDR_W or the pop on the same edge is accepted. On acceptance: mem[`wr_ptr`]←`data_in`, `wr_ptr` increments.
- **Push rejected** when `push`=1, the FIFO is full, and no accepted pop occurs on the same edge. Overflow: the word is dropped, memory is unchanged, error event raised.
- **Counter update**:
  - `count` += 1 when only the push is accepted.
  - `count` −= 1 when only the pop is accepted.
  - `count` is unchanged when both are accepted or neither is.
- **Simultaneous push+pop on empty**: the pop is an underflow and the push is accepted. Result: `count`=1, `fifo_error` raised.
- **Flags**: `fifo_empty`, `fifo_full`, `almost_*` are combinational compares of the registered `count` against the constants and the registered thresholds. They contain no other logic.

## Timing

- **Write to visible**: a push accepted at edge N makes `fifo_empty` deassert after edge N. A pop at edge N+1 returns that word.
- **Read latency**: 1 cycle. A pop at edge N gives `data_out` and `valid_out`=1 after edge N. `valid_out` returns to 0 after edge N+1 unless another pop is accepted at N+1.
- **Throughput**: one push and one pop per cycle, sustained.
- **Flags**: settle after the same edge that changes `count` or the thresholds.
- **Error event**: `fifo_error` rises after the offending edge.
- **Reset mid-operation**: asynchronous assertion clears all outputs to their reset values without waiting for `clk`. Memory contents are not cleared and are unreachable afterwards.

## Configuration

- **`FIFO_ERR_STICKY_EN` defined**: `fifo_error` latches at 1 on the first error event and holds until `reset`. This matches the FSM, which stays in ERROR until reset.
- **Not defined**: `fifo_error` is a one-cycle pulse after each offending edge, and 0 on every other cycle.
- Data path, pointers and flags are identical in both builds.

## Structure

- **Shared package `fifo_pkg`**:
  - localparams for default `DATA_W` and `ADDR_W`.
  - Threshold reset constants `TH_ALTO_RST` (2^ADDR_W−1) and `TH_BAJO_RST` (0).
  - The 8-bit threshold-bus field offsets used by the FSM: MF [7:6], VC [5:2], D [1:0].
- **Sub-module `fifo_mem`**: 2^ADDR_W × DATA_W register file.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - One asynchronous read port (`raddr` → `rdata`).
  - No reset on the array.
- **Top level** holds the pointers, counter, thresholds, output registers and flag compares.

## Test plan

1. **Reset**: with `reset`=0 held, then released → `fifo_empty`=1, `almost_empty`=1, `fifo_full`=0, `fifo_error`=0, `data_out`=0, `valid_out`=0.
2. **Fill**: with `umbral_we`=1 on one edge loading alto=12 and bajo=3, push 0x01..0x10 on 16 consecutive edges →
   - `almost_empty` falls after the 4th push.
   - `almost_full` rises after the 12th push.
   - `fifo_full`=1 after the 16th push.
   - Popping 16 times returns 0x01..0x10 in order, each with `valid_out`=1.
3. **Overflow**: when full, `push`=1 with `pop`=0 → `count` stays 16, contents are unchanged, `fifo_error`=1.
   - With `FIFO_ERR_STICKY_EN`: holds until reset.
   - Without it: a one-cycle pulse.
4. **Underflow**: when empty, `pop`=1 → `valid_out`=0, `fifo_error`=1. On a separate edge when empty, `push`=1 with `pop`=1 → `count`=1 and `fifo_error`=1.
5. **Simultaneous at full**: when full, `push`=1 with `pop`=1 for 20 cycles → `fifo_full` stays 1, no error, output order preserved across pointer wrap.
6. **Reset mid-stream**: with 7 entries and a pop in flight, assert `reset` between edges → flags and `data_out` return to reset values immediately. After release, the first pop gives underflow.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the threshold-aware FIFO instances.
// Holds default sizing, threshold reset values and FSM bus field offsets.
package fifo_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 4;

  function automatic int th_alto_rst(input int aw);
    return (1 << aw) - 1;
  endfunction

  localparam int TH_ALTO_RST = th_alto_rst(ADDR_W_DEF);
  localparam int TH_BAJO_RST = 0;

  // Per-FIFO fields on the FSM's 8-bit threshold bus
  localparam int MF_HI = 7;
  localparam int MF_LO = 6;
  localparam int VC_HI = 5;
  localparam int VC_LO = 2;
  localparam int D_HI  = 1;
  localparam int D_LO  = 0;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: 2^ADDR_W x DATA_W register file.
// One synchronous write port, one asynchronous read port, no array reset.
module fifo_mem #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_umbral.sv
// fifo_umbral: threshold-aware synchronous FIFO with registered read data.
// Define FIFO_ERR_STICKY_EN to latch fifo_error until reset.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic              umbral_we,
  input  logic [ADDR_W-1:0] umbral_alto,
  input  logic [ADDR_W-1:0] umbral_bajo,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              fifo_error
);

  localparam logic [ADDR_W:0] FULL_CNT =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ALTO_RST =
    ADDR_W'(th_alto_rst(ADDR_W));
  localparam logic [ADDR_W-1:0] BAJO_RST =
    ADDR_W'(TH_BAJO_RST);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] th_alto_q, th_alto_d;
  logic [ADDR_W-1:0] th_bajo_q, th_bajo_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              pop_ok;
  logic              push_ok;
  logic              err_ev;
  logic [DATA_W-1:0] rdata;

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // A pop on the same edge frees a slot, so push at full is legal then
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != FULL_CNT) || pop_ok);
  assign err_ev  = (pop && !pop_ok) || (push && !push_ok);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    th_alto_d = th_alto_q;
    th_bajo_d = th_bajo_q;
    dout_d    = dout_q;
    valid_d   = pop_ok;
    if (pop_ok) begin
      dout_d   = rdata;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    if (umbral_we) begin
      th_alto_d = umbral_alto;
      th_bajo_d = umbral_bajo;
    end
`ifdef FIFO_ERR_STICKY_EN
    err_d = err_q | err_ev;
`else
    err_d = err_ev;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      th_alto_q <= ALTO_RST;
      th_bajo_q <= BAJO_RST;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      th_alto_q <= th_alto_d;
      th_bajo_q <= th_bajo_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign data_out     = dout_q;
  assign valid_out    = valid_q;
  assign fifo_error   = err_q;
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == FULL_CNT);
  assign almost_empty = (count_q <= {1'b0, th_bajo_q});
  assign almost_full  = (count_q >= {1'b0, th_alto_q});

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: directed plus random steps against a queue-based model.
// Honours FIFO_ERR_STICKY_EN in the model's error behaviour.
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop, umbral_we;
  logic [5:0] data_in, data_out;
  logic [3:0] umbral_alto, umbral_bajo;
  logic       valid_out, fifo_empty, fifo_full;
  logic       almost_empty, almost_full, fifo_error;

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] m_q[$];
  int         m_alto, m_bajo;
  logic [5:0] m_dout;
  logic       m_valid, m_err;

  always #5 clk = ~clk;

  fifo_umbral dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .umbral_we    (umbral_we),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fifo_error   (fifo_error)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_alto  = 15;
    m_bajo  = 0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".data_out"}, 8'(data_out), 8'(m_dout));
    chk({tag, ".valid"}, 8'(valid_out), 8'(m_valid));
    chk({tag, ".empty"}, 8'(fifo_empty), 8'(n == 0));
    chk({tag, ".full"}, 8'(fifo_full), 8'(n == 16));
    chk({tag, ".a_empty"}, 8'(almost_empty), 8'(n <= m_bajo));
    chk({tag, ".a_full"}, 8'(almost_full), 8'(n >= m_alto));
    chk({tag, ".error"}, 8'(fifo_error), 8'(m_err));
  endtask

  task automatic step(input string tag, input logic ps,
                      input logic [5:0] d, input logic pp,
                      input logic we, input logic [3:0] a,
                      input logic [3:0] b);
    bit pok, uok, ev;
    push = ps; data_in = d; pop = pp;
    umbral_we = we; umbral_alto = a; umbral_bajo = b;
    @(posedge clk);
    pok = pp && (m_q.size() > 0);
    uok = ps && ((m_q.size() < 16) || pok);
    ev  = (pp && !pok) || (ps && !uok);
    if (pok) m_dout = m_q.pop_front();
    m_valid = pok;
    if (uok) m_q.push_back(d);
    if (we) begin
      m_alto = int'(a);
      m_bajo = int'(b);
    end
`ifdef FIFO_ERR_STICKY_EN
    m_err = m_err | ev;
`else
    m_err = ev;
`endif
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    step("idle", 1'b0, 6'h0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  initial begin
    push = 0; pop = 0; umbral_we = 0; data_in = '0;
    umbral_alto = '0; umbral_bajo = '0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_all("rst_held");
    reset = 1'b1;
    #1;
    check_all("rst_rel");
    @(posedge clk);
    #1;
    check_all("rst_idle");

    step("th_load", 1'b0, 6'h0, 1'b0, 1'b1, 4'd12, 4'd3);
    for (int i = 1; i <= 16; i++)
      step("fill", 1'b1, 6'(i), 1'b0, 1'b0, 4'h0, 4'h0);
    chk("fill.full", 8'(fifo_full), 8'd1);

    step("ovf", 1'b1, 6'h3F, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("ovf.err", 8'(fifo_error), 8'd1);
    idle();
    idle();

    for (int i = 1; i <= 16; i++) begin
      step("drain", 1'b0, 6'h0, 1'b1, 1'b0, 4'h0, 4'h0);
      chk("drain.order", 8'(data_out), 8'(i));
    end

    step("udf", 1'b0, 6'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("udf.err", 8'(fifo_error), 8'd1);
    idle();
    step("udf_push", 1'b1, 6'h2A, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("udf_push.err", 8'(fifo_error), 8'd1);
    chk("udf_push.empty", 8'(fifo_empty), 8'd0);
    idle();

    for (int i = 0; i < 15; i++)
      step("refill", 1'b1, 6'($urandom), 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++)
      step("both_full", 1'b1, 6'($urandom), 1'b1, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++)
      step("drain2", 1'b0, 6'h0, 1'b1, 1'b0, 4'h0, 4'h0);

    for (int i = 0; i < 400; i++) begin
      logic ps, pp, we;
      int   bias;
      bias = ((i / 50) % 2 == 0) ? 80 : 25;
      ps = ($urandom_range(0, 99) < bias);
      pp = ($urandom_range(0, 99) < (100 - bias));
      we = ($urandom_range(0, 15) == 0);
      step("rand", ps, 6'($urandom), pp, we,
           4'($urandom), 4'($urandom));
    end

    for (int i = 0; i < 17; i++)
      step("drain3", 1'b0, 6'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 7; i++)
      step("seven", 1'b1, 6'(i + 8), 1'b0, 1'b0, 4'h0, 4'h0);
    step("inflight", 1'b0, 6'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    #2;
    reset = 1'b1;
    step("post_rst", 1'b0, 6'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("post_rst.err", 8'(fifo_error), 8'd1);
    chk("post_rst.valid", 8'(valid_out), 8'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
